// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default bus widths
// and a counter-width helper used by master and slave.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  function automatic int cnt_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB request/response
// signals; master modport is the apb_master view.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready;
  logic              P_slverr;
  logic [DATA_W-1:0] P_rdata;

  modport master (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  P_ready, P_slverr, P_rdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata,
    output rsp_slverr, rsp_timeout,
    output P_addr, P_selx, P_enable,
    output P_write, P_wdata
  );

  modport slave (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    output rsp_ready,
    output P_ready, P_slverr, P_rdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_slverr, rsp_timeout,
    input  P_addr, P_selx, P_enable,
    input  P_write, P_wdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired flags the edge that
// is the TIMEOUT-th ACCESS edge. TIMEOUT=0 never expires.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  // wait counter, restarted for every new transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB master: accepts one command at a time, runs the
// SETUP/ACCESS phases and returns a registered response.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic          P_clk,
  input  logic          P_rst_n,
  apb_master_if.master  bus
);

  apb_state_e state;
  apb_state_e state_n;

  logic              ready;
  logic              accept;
  logic              done_ok;
  logic              done_to;
  logic              wait_en;
  logic              expired;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              selx_q;
  logic              enable_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              slverr_q;
  logic              timeout_q;

  assign ready = P_rst_n && (state == IDLE)
              && (!rsp_valid_q || bus.rsp_ready);
  assign accept  = bus.cmd_valid && ready;
  assign done_ok = (state == ACCESS) && bus.P_ready;
  assign done_to = (state == ACCESS) && !bus.P_ready
                && expired;
  assign wait_en = (state == ACCESS) && !bus.P_ready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (P_clk),
    .rst_n   (P_rst_n),
    .clear   (accept),
    .enable  (wait_en),
    .expired (expired)
  );

  // state register
  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   state_n = ACCESS;
      ACCESS:  if (done_ok || done_to) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // registered bus and response outputs
  always_ff @(posedge P_clk or negedge P_rst_n) begin
    if (!P_rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      selx_q      <= 1'b0;
      enable_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      slverr_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (bus.rsp_ready) rsp_valid_q <= 1'b0;
      unique case (1'b1)
        accept: begin
          addr_q   <= bus.cmd_addr;
          write_q  <= bus.cmd_write;
          wdata_q  <= bus.cmd_wdata;
          selx_q   <= 1'b1;
          enable_q <= 1'b0;
        end
        (state == SETUP): begin
          enable_q <= 1'b1;
        end
        done_ok: begin
          rsp_valid_q <= 1'b1;
          rdata_q     <= write_q ? '0 : bus.P_rdata;
          slverr_q    <= bus.P_slverr;
          timeout_q   <= 1'b0;
          selx_q      <= 1'b0;
          enable_q    <= 1'b0;
        end
        done_to: begin
          rsp_valid_q <= 1'b1;
          rdata_q     <= '0;
          slverr_q    <= 1'b1;
          timeout_q   <= 1'b1;
          selx_q      <= 1'b0;
          enable_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_slverr  = slverr_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.P_addr      = addr_q;
  assign bus.P_selx      = selx_q;
  assign bus.P_enable    = enable_q;
  assign bus.P_write     = write_q;
  assign bus.P_wdata     = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with a behavioural
// APB slave and a memory reference model.
module tb_apb_master;

  localparam int TMO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          wt;
    logic        e;
    longint      cyc;
  } txn_t;

  typedef struct {
    int   wt;
    logic e;
  } scfg_t;

  logic P_clk;
  logic P_rst_n;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .P_clk   (P_clk),
    .P_rst_n (P_rst_n),
    .bus     (bus)
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  txn_t  exp_q[$];
  scfg_t slv_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] smem    [logic [31:0]];

  int   cfg_wait = 0;
  logic cfg_err  = 1'b0;
  logic rr_rand  = 1'b0;

  initial begin
    P_clk = 1'b0;
    forever #5 P_clk = ~P_clk;
  end

  always @(posedge P_clk) cyc <= cyc + 1;

  function automatic void chk(string n,
    logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, expv);
    end
  endfunction

  function automatic void bad(string n);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", n);
  endfunction

  // ---------------- behavioural slave ----------------
  int          s_cnt  = 0;
  logic        s_act  = 1'b0;
  logic        s_err  = 1'b0;
  logic        s_com  = 1'b0;
  logic [31:0] s_ca;
  logic [31:0] s_cd;

  always @(posedge P_clk) begin
    #1;
    if (!P_rst_n) begin
      slv_q.delete();
      s_act = 1'b0;
      s_com = 1'b0;
      bus.P_ready = 1'b0;
    end else begin
      if (s_com) begin
        smem[s_ca] = s_cd;
        s_com = 1'b0;
      end
      if (bus.P_selx && !bus.P_enable) begin
        if (slv_q.size() == 0) begin
          bad("slave_no_cfg");
          s_cnt = 0;
          s_err = 1'b0;
        end else begin
          scfg_t c;
          c = slv_q.pop_front();
          s_cnt = c.wt;
          s_err = c.e;
        end
        s_act = 1'b1;
        bus.P_ready  = 1'($urandom_range(1));
        bus.P_slverr = 1'($urandom_range(1));
        bus.P_rdata  = $urandom;
      end else if (bus.P_selx && bus.P_enable
                   && s_act) begin
        if (s_cnt == 0) begin
          bus.P_ready  = 1'b1;
          bus.P_slverr = s_err;
          if (s_err) bus.P_rdata = ERRD;
          else if (smem.exists(bus.P_addr))
            bus.P_rdata = smem[bus.P_addr];
          else bus.P_rdata = '0;
          if (bus.P_write && !s_err) begin
            s_com = 1'b1;
            s_ca  = bus.P_addr;
            s_cd  = bus.P_wdata;
          end
          s_act = 1'b0;
        end else begin
          bus.P_ready  = 1'b0;
          bus.P_slverr = 1'($urandom_range(1));
          bus.P_rdata  = $urandom;
          s_cnt--;
        end
      end else begin
        s_act = 1'b0;
        bus.P_ready  = 1'($urandom_range(1));
        bus.P_slverr = 1'($urandom_range(1));
        bus.P_rdata  = $urandom;
      end
    end
  end

  always @(posedge P_clk) begin
    #1;
    if (rr_rand)
      bus.rsp_ready = ($urandom_range(3) != 0);
  end

  // ---------------- monitor / scoreboard -------------
  logic        shown = 1'b0;
  logic [31:0] h_rd;
  logic        h_se;
  logic        h_to;
  int          sel_cnt = 0;
  int          en_cnt  = 0;
  logic [31:0] cur_a;
  logic [31:0] cur_d;
  logic        cur_w;

  function automatic void check_rsp(txn_t t);
    logic        to;
    logic [31:0] er;
    int          lat;
    to = (t.wt >= TMO);
    if (t.w || to) er = '0;
    else if (t.e) er = ERRD;
    else if (ref_mem.exists(t.a)) er = ref_mem[t.a];
    else er = '0;
    lat = to ? 1 + TMO : 2 + t.wt;
    chk("rsp_rdata", bus.rsp_rdata, er);
    chk("rsp_slverr", bus.rsp_slverr, to || t.e);
    chk("rsp_timeout", bus.rsp_timeout, to);
    chk("rsp_latency", cyc, t.cyc + lat);
    chk("selx_cycles", sel_cnt, lat);
    chk("enable_cycles", en_cnt, lat - 1);
    chk("selx_after_done", bus.P_selx, 0);
    if (t.w && !to && !t.e) ref_mem[t.a] = t.d;
  endfunction

  always @(negedge P_clk) begin
    if (!P_rst_n) begin
      exp_q.delete();
      shown = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (!shown) begin
          if (exp_q.size() == 0) begin
            bad("unexpected_rsp");
          end else begin
            check_rsp(exp_q.pop_front());
          end
          shown = 1'b1;
          h_rd = bus.rsp_rdata;
          h_se = bus.rsp_slverr;
          h_to = bus.rsp_timeout;
        end else begin
          chk("hold_rdata", bus.rsp_rdata, h_rd);
          chk("hold_slverr", bus.rsp_slverr, h_se);
          chk("hold_timeout", bus.rsp_timeout, h_to);
        end
        if (bus.rsp_ready) shown = 1'b0;
      end
      if (bus.P_enable)
        chk("enable_needs_selx", bus.P_selx, 1);
      if (bus.P_selx) begin
        chk("paddr_stable", bus.P_addr, cur_a);
        chk("pwrite_stable", bus.P_write, cur_w);
        chk("pwdata_stable", bus.P_wdata, cur_d);
        sel_cnt++;
      end
      if (bus.P_enable) en_cnt++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        txn_t  t;
        scfg_t c;
        t.w = bus.cmd_write;
        t.a = bus.cmd_addr;
        t.d = bus.cmd_wdata;
        t.wt = cfg_wait;
        t.e = cfg_err;
        t.cyc = cyc + 1;
        exp_q.push_back(t);
        c.wt = cfg_wait;
        c.e  = cfg_err;
        slv_q.push_back(c);
        cur_a = bus.cmd_addr;
        cur_w = bus.cmd_write;
        cur_d = bus.cmd_wdata;
        sel_cnt = 0;
        en_cnt  = 0;
      end
    end
  end

  // ---------------- stimulus -------------------------
  task automatic set_cmd(input logic w,
    input logic [31:0] a, input logic [31:0] d,
    input int wt, input logic e);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    cfg_wait = wt;
    cfg_err  = e;
    bus.cmd_valid = 1'b1;
  endtask

  task automatic issue(input logic w,
    input logic [31:0] a, input logic [31:0] d,
    input int wt, input logic e);
    int n;
    n = 0;
    @(posedge P_clk);
    #1;
    set_cmd(w, a, d, wt, e);
    forever begin
      @(negedge P_clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 200) begin
        bad("accept_timeout");
        break;
      end
    end
    @(posedge P_clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge P_clk);
      n++;
    end while ((exp_q.size() != 0 || bus.rsp_valid)
               && n < 100);
    if (n >= 100) bad("drain_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.P_ready   = 1'b0;
    bus.P_slverr  = 1'b0;
    bus.P_rdata   = '0;
    P_rst_n = 1'b1;
    #2;
    P_rst_n = 1'b0;
    bus.cmd_valid = 1'b1;
    #10;
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_selx", bus.P_selx, 0);
    chk("rst_enable", bus.P_enable, 0);
    chk("rst_addr", bus.P_addr, 0);
    chk("rst_wdata", bus.P_wdata, 0);
    chk("rst_write", bus.P_write, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_slverr", bus.rsp_slverr, 0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    bus.cmd_valid = 1'b0;
    @(posedge P_clk);
    #3;
    P_rst_n = 1'b1;

    // zero-wait write, then 3-wait read back
    issue(1'b1, 32'd5, 32'hA5, 0, 1'b0);
    drain();
    issue(1'b0, 32'd5, 32'h0, 3, 1'b0);
    drain();

    // slave never ready: timeout
    issue(1'b0, 32'd6, 32'h0, 100, 1'b0);
    drain();

    // slave error with ready
    issue(1'b0, 32'd5, 32'h0, 0, 1'b1);
    drain();
    issue(1'b1, 32'd7, 32'h77, 2, 1'b1);
    drain();

    // response backpressure blocks next command
    bus.rsp_ready = 1'b0;
    issue(1'b1, 32'd9, 32'h5A, 1, 1'b0);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++)
      @(negedge P_clk);
    @(posedge P_clk);
    #1;
    set_cmd(1'b0, 32'd9, 32'h0, 0, 1'b0);
    repeat (5) begin
      @(negedge P_clk);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
    end
    @(posedge P_clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge P_clk);
    chk("bp_release_ready", bus.cmd_ready, 1);
    @(posedge P_clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", bus.P_selx, 1);
    drain();

    // reset in the middle of ACCESS
    issue(1'b1, 32'h20, 32'h1234, 3, 1'b0);
    @(posedge P_clk);
    @(posedge P_clk);
    #2;
    chk("mid_access_enable", bus.P_enable, 1);
    P_rst_n = 1'b0;
    #1;
    chk("arst_selx", bus.P_selx, 0);
    chk("arst_enable", bus.P_enable, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    set_cmd(1'b1, 32'h21, 32'h77, 0, 1'b0);
    repeat (2) begin
      @(negedge P_clk);
      chk("arst_cmd_ready", bus.cmd_ready, 0);
      chk("arst_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge P_clk);
    #3;
    P_rst_n = 1'b1;
    @(posedge P_clk);
    #1;
    chk("first_edge_accept", bus.P_selx, 1);
    bus.cmd_valid = 1'b0;
    drain();
    issue(1'b0, 32'h20, 32'h0, 0, 1'b0);
    drain();
    issue(1'b0, 32'h21, 32'h0, 1, 1'b0);
    drain();

    // randomized traffic with backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(1)),
            32'($urandom_range(7)), $urandom,
            $urandom_range(5),
            ($urandom_range(7) == 0));
    end
    rr_rand = 1'b0;
    @(posedge P_clk);
    #2;
    bus.rsp_ready = 1'b1;
    drain();
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 32'(i), 32'h0, 0, 1'b0);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum number of ACCESS cycles spent waiting for P_ready; 0 disables the timeout.
REQ-004 SHALL have port P_clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port P_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1, a transfer request is present.
REQ-007 SHALL have port cmd_ready, output, 1, request accepted on an edge where cmd_valid=1.
REQ-008 SHALL have port cmd_write, input, 1, 1=write, 0=read.
REQ-009 SHALL have port cmd_addr, input, ADDR_W, transfer address.
REQ-010 SHALL have port cmd_wdata, input, DATA_W, write data.
REQ-011 SHALL have port rsp_valid, output, 1, a completion is present.
REQ-012 SHALL have port rsp_ready, input, 1, the consumer takes the completion.
REQ-013 SHALL have port rsp_rdata, output, DATA_W, read data; 0 for writes and timeouts.
REQ-014 SHALL have port rsp_slverr, output, 1, slave error or timeout.
REQ-015 SHALL have port rsp_timeout, output, 1, completion caused by timeout.
REQ-016 SHALL have ports P_addr (ADDR_W), P_selx (1), P_enable (1), P_write (1) and P_wdata (DATA_W), all outputs, forming the APB request to the slave.
REQ-017 SHALL have ports P_ready (1), P_slverr (1) and P_rdata (DATA_W), all inputs, forming the APB response from the slave.

Function
REQ-018 SHALL implement state machine IDLE, SETUP, ACCESS; all outputs SHALL be driven from registers.
REQ-019 SHALL compute cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready), so back-to-back transfers are possible when the response is consumed on the same edge.
REQ-020 SHALL, on acceptance, latch cmd_addr, cmd_write and cmd_wdata onto P_addr, P_write and P_wdata, set P_selx=1 and P_enable=0, and enter SETUP.
REQ-021 SHALL hold P_addr, P_write and P_wdata stable throughout SETUP and ACCESS.
REQ-022 SHALL move from SETUP to ACCESS unconditionally after one cycle, setting P_enable=1.
REQ-023 SHALL, in ACCESS on an edge with P_ready=1: capture P_rdata (reads only, else 0) and P_slverr; set rsp_valid=1 and rsp_timeout=0; clear P_selx and P_enable; enter IDLE.
REQ-024 SHALL count ACCESS cycles; if TIMEOUT!=0 and the TIMEOUT-th ACCESS edge sees P_ready=0, it SHALL complete with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, clear P_selx and P_enable, and enter IDLE.
REQ-025 SHALL give P_ready=1 priority over timeout on the same edge.
REQ-026 SHALL reset the wait counter on every entry to SETUP.
REQ-027 SHALL provide zero-wait latency as: accept at edge N, SETUP in cycle N..N+1, ACCESS sampled at N+2, rsp_valid high after edge N+2.
REQ-028 SHALL hold rsp_valid and the rsp_* fields stable until the edge with rsp_ready=1, then clear rsp_valid unless a new completion occurs on that same edge.
REQ-029 SHALL ignore P_ready, P_slverr and P_rdata outside ACCESS.
REQ-030 SHALL never assert P_enable without P_selx.

Reset
REQ-031 SHALL, on P_rst_n low, immediately force state=IDLE, P_selx=0, P_enable=0, P_write=0, P_addr=0, P_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0 and counter=0.
REQ-032 SHALL abandon an in-flight transfer on reset mid-SETUP or mid-ACCESS, producing no response.
REQ-033 SHALL hold cmd_ready=0 while P_rst_n is low and accept a command on the first edge after release.

Structure
REQ-034 SHALL place the state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the default ADDR_W and DATA_W in shared package apb_pkg, which the APB slave also uses.
REQ-035 SHALL implement the wait/timeout counter as sub-module apb_wait_timer (inputs clear, enable; output expired).

Verification
REQ-036 Bench SHALL cover: write addr=5, wdata=0xA5, slave P_ready=1 in first ACCESS -> P_selx high 2 cycles, P_enable high 1 cycle, rsp_valid 2 cycles after accept, rsp_slverr=0.
REQ-037 Bench SHALL cover: read addr=5 after that write, slave with 3 wait states -> rsp_rdata=0xA5, rsp_valid 5 cycles after accept, P_addr stable throughout.
REQ-038 Bench SHALL cover: TIMEOUT=4, P_ready held 0 -> after 4 ACCESS cycles rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, P_selx=0.
REQ-039 Bench SHALL cover: slave returns P_slverr=1 with P_ready=1 -> rsp_slverr=1, rsp_timeout=0.
REQ-040 Bench SHALL cover: rsp_ready held 0 for 5 cycles with cmd_valid=1 -> cmd_ready=0 and response stable; then rsp_ready=1 -> next command accepted on the same edge.
REQ-041 Bench SHALL cover: P_rst_n pulsed low mid-ACCESS -> P_selx and P_enable drop asynchronously, no rsp_valid, next write completes normally.
